// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 @ 60 Hz raster timing constants shared by vga_sync and the character generator
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_DISPLAY = 10'd640;
  localparam coord_t H_FP      = 10'd16;
  localparam coord_t H_SYNC    = 10'd96;
  localparam coord_t H_BP      = 10'd48;
  localparam coord_t H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;

  localparam coord_t V_DISPLAY = 10'd480;
  localparam coord_t V_FP      = 10'd10;
  localparam coord_t V_SYNC    = 10'd2;
  localparam coord_t V_BP      = 10'd33;
  localparam coord_t V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [start, end)
  localparam coord_t H_SYNC_START = H_DISPLAY + H_FP;
  localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam coord_t V_SYNC_START = V_DISPLAY + V_FP;
  localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction
endpackage

// File: rtl/vga_sync_pix_tick_gen.sv
// rtl/vga_sync_pix_tick_gen.sv - pix_tick_gen: divides clk by CLK_DIV into a one-clk pixel strobe
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) div_cnt_q <= '0;
    else          div_cnt_q <= div_cnt_d;
  end

  assign p_tick = (div_cnt_q == LAST);
endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA scan counters and sync/colour output stage; VGA_BORDER_TEST_EN adds a white alignment border
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [2:0]   rgb_in,
  output logic [9:0]   pixel_x,
  output logic [9:0]   pixel_y,
  output logic         video_on,
  output logic         p_tick,
  output logic         frame_tick,
  output logic         hsync,
  output logic         vsync,
  output logic [2:0]   rgb_out
);
  logic       tick;
  coord_t     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;
  logic       h_last, v_last, vis, hs_raw, vs_raw;
  logic [2:0] pix_rgb;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (tick)
  );

  always_comb begin
    h_last  = (h_cnt_q == H_TOTAL - 10'd1);
    v_last  = (v_cnt_q == V_TOTAL - 10'd1);
    vis     = (h_cnt_q < H_DISPLAY) && (v_cnt_q < V_DISPLAY);
    hs_raw  = !in_window(h_cnt_q, H_SYNC_START, H_SYNC_END);
    vs_raw  = !in_window(v_cnt_q, V_SYNC_START, V_SYNC_END);
    pix_rgb = rgb_in;
`ifdef VGA_BORDER_TEST_EN
    if ((h_cnt_q == 10'd0) || (h_cnt_q == H_DISPLAY - 10'd1) ||
        (v_cnt_q == 10'd0) || (v_cnt_q == V_DISPLAY - 10'd1))
      pix_rgb = 3'b111;
`endif
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    // Output stage samples the current coordinates, so it trails them by one pixel
    if (tick) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 10'd1;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      hsync_d = hs_raw;
      vsync_d = vs_raw;
      rgb_d   = vis ? pix_rgb : 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pixel_x    = h_cnt_q;
  assign pixel_y    = v_cnt_q;
  assign video_on   = vis;
  assign p_tick     = tick;
  assign frame_tick = tick && h_last && v_last;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb_out    = rgb_q;
endmodule

// File: doc/vga_sync.md
# vga_sync

Raster timing source for the 640x480 @ 60 Hz text display. Divides the system clock down to the pixel rate, runs the horizontal/vertical scan counters, and drives `pixel_x`/`pixel_y` to the character generator. It registers the generator's 3-bit colour back out to the monitor with blanking applied, aligned with `hsync`/`vsync`. Instantiated once at top level, between the board clock/reset and the VGA connector.

## Interface
Parameters:
- `CLK_DIV`, default 2: system clocks per pixel. The 50 MHz board clock gives a 25 MHz pixel rate. Legal values are 2–8.

Ports (clock and reset first):
- `clk` input, 1: system clock. It is the only clock.
- `reset_n` input, 1: synchronous, active-low reset.
- `rgb_in` input, 3: colour from the character generator for the current `pixel_x`/`pixel_y`.
- `pixel_x` output, 10: current horizontal count, 0–799.
- `pixel_y` output, 10: current vertical count, 0–524.
- `video_on` output, 1: high while the counts are inside the visible 640x480 area.
- `p_tick` output, 1: one-`clk` strobe at the pixel rate.
- `frame_tick` output, 1: one-`clk` strobe at the end of each frame.
- `hsync` output, 1: horizontal sync, active-low, pipelined to match `rgb_out`.
- `vsync` output, 1: vertical sync, active-low, pipelined to match `rgb_out`.
- `rgb_out` output, 3: colour to the DAC pins. Forced to 0 during blanking.

## Operation
- Divider: `div_cnt` counts modulo `CLK_DIV`. `p_tick` = (`div_cnt` == `CLK_DIV`-1).
- Horizontal counter `h_cnt` advances on `p_tick` and wraps 799→0.
  - Regions: display 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- Vertical counter `v_cnt` advances on `p_tick` only when `h_cnt` wraps, and itself wraps 524→0.
  - Regions: display 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- `pixel_x` = `h_cnt` and `pixel_y` = `v_cnt`, driven directly from the registers.
- `video_on` = (`h_cnt` < 640) && (`v_cnt` < 480). It is combinational from the counters.
- Raw syncs are combinational from the counters:
  - `hs_raw` = low for `h_cnt` 656–751.
  - `vs_raw` = low for `v_cnt` 490–491.
- Output stage, updated on `p_tick` only:
  - `hsync` <= `hs_raw`
  - `vsync` <= `vs_raw`
  - `rgb_out` <= `video_on` ? `rgb_in` : 0
- `frame_tick` = `p_tick` && `h_cnt`==799 && `v_cnt`==524. Downstream logic uses it to latch new date/time values without tearing.
- Simultaneous wraps: when both counters wrap on the same `p_tick`, both go to 0 together. `frame_tick` is asserted in the cycle before that.
- Reset is synchronous and overrides everything, including reset mid-frame or mid-`p_tick`. It forces:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0
  - `hsync`=1, `vsync`=1, `rgb_out`=0
- Output values in the first cycle after reset: `p_tick`=0 (unless `CLK_DIV`==1, which is illegal), `frame_tick`=0, `video_on`=1, `pixel_x`=`pixel_y`=0.

## Timing
- `p_tick` fires every `CLK_DIV` clocks. The first pulse comes `CLK_DIV` clocks after `reset_n` is released.
- The counters change in the `clk` edge that samples `p_tick`=1.
- The character generator's font ROM has 1 `clk` of latency. `rgb_in` must therefore be valid no later than `CLK_DIV`-1 clocks after the coordinates change; this requires `CLK_DIV` ≥ 2.
- `rgb_out`, `hsync` and `vsync` lag `pixel_x`/`pixel_y` by exactly one pixel (`CLK_DIV` clocks). They are mutually aligned.
- Line period is 800 pixels; frame period is 525 lines = 420 000 pixels.
- `hsync` low width is 96 pixels; `vsync` low width is 2 lines (1600 pixels).

## Configuration
- `VGA_BORDER_TEST_EN` defined: `rgb_out` is forced to 3'b111 wherever any of these hold:
  - `h_cnt`==0
  - `h_cnt`==639
  - `v_cnt`==0
  - `v_cnt`==479
  
  This draws a 1-pixel white frame for monitor alignment. `rgb_in` is used everywhere else in the visible area.
- `VGA_BORDER_TEST_EN` undefined: `rgb_out` is always `video_on` ? `rgb_in` : 0. The border logic is absent.

## Structure
- Package `vga_timing_pkg` holds the timing constants:
  - `H_DISPLAY`=640, `H_FP`=16, `H_SYNC`=96, `H_BP`=48, `H_TOTAL`=800
  - `V_DISPLAY`=480, `V_FP`=10, `V_SYNC`=2, `V_BP`=33, `V_TOTAL`=525
  
  The character generator imports the same package for its display limits.
- Sub-module `pix_tick_gen` contains the `CLK_DIV` divider, with ports `clk`, `reset_n` → `p_tick`. Everything else stays in `vga_sync`.

## Test plan
- **Reset/divider:** hold `reset_n`=0 for 5 clks, then release → `pixel_x`=`pixel_y`=0, `hsync`=`vsync`=1, `rgb_out`=0. With `CLK_DIV`=2, `p_tick` goes high on clks 2, 4, 6, …
- **Horizontal wrap:** run one line → `pixel_x` goes 0…799→0 and `pixel_y` increments once. `hsync` is low for exactly 96 pixels, starting one pixel after `pixel_x`=656.
- **Vertical/frame:** run a full frame → `vsync` is low for exactly 1600 pixels, starting one pixel after `v_cnt`=490. `frame_tick` pulses exactly once per 420 000 `p_tick`s, with `h_cnt`=799 and `v_cnt`=524.
- **Blanking:** drive `rgb_in`=3'b101 constant →
  - `rgb_out`=3'b101 for display pixels.
  - `rgb_out`=0 one pixel after `pixel_x` reaches 640.
  - `rgb_out`=0 throughout `v_cnt` 480–524.
- **Reset mid-frame:** assert `reset_n`=0 at `h_cnt`=700, `v_cnt`=491 (`hsync`/`vsync` low) → on the next clk `hsync`=`vsync`=1, counters are 0, and there is no `frame_tick`.
- **`VGA_BORDER_TEST_EN`:** compile with the macro and drive `rgb_in`=0 → `rgb_out`=3'b111 only at columns 0/639 and rows 0/479, 0 elsewhere. Without the macro → `rgb_out`=0 everywhere.
